shift_register: RTL and testbench

Parametrised universal shift register for the sequential shift-add multiplier datapath. It replaces the plain load/clear register wherever an operand or partial product must be shifted. Each cycle it can hold, parallel-load, synchronously clear, or shift one bit in either direction with a serial input. An optional built-in shift counter reports when W shifts have completed, so the multiplier controller needs no separate iteration counter.

---
 rtl/shift_register_pkg.sv | 15 +
 rtl/shift_register_counter.sv | 29 ++
 rtl/shift_register.sv | 75 +++++++
 tb/tb_shift_register.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// Shared types for the universal shift register.
// Mode encodings and mode width.
package shift_register_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SHM_HOLD = 3'd0,
    SHM_LOAD = 3'd1,
    SHM_SHR  = 3'd2,
    SHM_SHL  = 3'd3,
    SHM_CLR  = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/shift_register_counter.sv
// shift_counter: counts shifts since LOAD/CLR, saturating at W.
// Ports: clk, clear_n, clr, inc -> count, done.
module shift_counter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] LIMIT = CW'(W);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT);

endmodule

// File: rtl/shift_register.sv
// Universal shift register: hold/load/clear/shift-by-one.
// Ports: clk, clear_n, mode, in, sin, arith -> out, sout,
// count, done. Counter built only if SHIFT_REGISTER_COUNT_EN.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [MODE_W-1:0] mode,
  input  logic [W-1:0]      in,
  input  logic              sin,
  input  logic              arith,
  output logic [W-1:0]      out,
  output logic              sout,
  output logic [CW-1:0]     count,
  output logic              done
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out  <= '0;
      sout <= 1'b0;
    end else begin
      unique case (mode)
        SHM_LOAD: begin
          out  <= in;
          sout <= 1'b0;
        end
        SHM_SHR: begin
          out  <= {(arith ? out[W-1] : sin),
                   out[W-1:1]};
          sout <= out[0];
        end
        SHM_SHL: begin
          out  <= {out[W-2:0], sin};
          sout <= out[W-1];
        end
        SHM_CLR: begin
          out  <= '0;
          sout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_REGISTER_COUNT_EN
  logic clr;
  logic inc;

  assign clr = (mode == SHM_LOAD) ||
               (mode == SHM_CLR);
  assign inc = (mode == SHM_SHR) ||
               (mode == SHM_SHL);

  shift_counter #(
    .W  (W),
    .CW (CW)
  ) u_cnt (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (clr),
    .inc     (inc),
    .count   (count),
    .done    (done)
  );
`else
  assign count = '0;
  assign done  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register at W=8 and W=16.
// Count expectations follow SHIFT_REGISTER_COUNT_EN.
module tb_shift_register;

  logic       clk;
  logic       clear_n;
  logic [2:0] mode;
  logic [7:0] din;
  logic       sin;
  logic       arith;
  logic [7:0] out8;
  logic       sout8;
  logic [3:0] cnt8;
  logic       done8;

  logic [2:0]  m16;
  logic [15:0] d16;
  logic        s16;
  logic [15:0] out16;
  logic        sout16;
  logic [4:0]  cnt16;
  logic        done16;

  int n_cmp = 0;
  int n_bad = 0;

  shift_register #(.W(8)) dut8 (
    .clk     (clk),
    .clear_n (clear_n),
    .mode    (mode),
    .in      (din),
    .sin     (sin),
    .arith   (arith),
    .out     (out8),
    .sout    (sout8),
    .count   (cnt8),
    .done    (done8)
  );

  shift_register #(.W(16)) dut16 (
    .clk     (clk),
    .clear_n (clear_n),
    .mode    (m16),
    .in      (d16),
    .sin     (s16),
    .arith   (1'b0),
    .out     (out16),
    .sout    (sout16),
    .count   (cnt16),
    .done    (done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ec(input int n);
`ifdef SHIFT_REGISTER_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] m,
                      input logic [7:0] d,
                      input logic s,
                      input logic a);
    @(negedge clk);
    mode  = m;
    din   = d;
    sin   = s;
    arith = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag,
                      input logic [7:0] o,
                      input logic so,
                      input int c,
                      input logic dn);
    chk({tag, ".out"},   32'(out8),  32'(o));
    chk({tag, ".sout"},  32'(sout8), 32'(so));
    chk({tag, ".count"}, 32'(cnt8),  32'(ec(c)));
    chk({tag, ".done"},  32'(done8),
        32'(dn && ec(1) == 1));
  endtask

  initial begin
    clear_n = 1'b0;
    mode = 3'd0; din = '0; sin = 0; arith = 0;
    m16 = 3'd0; d16 = '0; s16 = 0;
    #12;
    chk8("rst", 8'h00, 0, 0, 0);
    chk("rst16.out", 32'(out16), 32'h0);
    @(negedge clk);
    clear_n = 1'b1;

    // build A5 with count 3, then async clear
    step(3'd1, 8'h14, 0, 0);
    step(3'd3, 8'h00, 1, 0);
    chk8("shl1", 8'h29, 0, 1, 0);
    step(3'd3, 8'h00, 0, 0);
    step(3'd3, 8'h00, 1, 0);
    chk8("pre_rst", 8'hA5, 0, 3, 0);
    mode = 3'd0;
    #2 clear_n = 1'b0;
    #1 chk8("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk);
    clear_n = 1'b1;

    step(3'd1, 8'hB4, 1, 1);
    chk8("load", 8'hB4, 0, 0, 0);
    step(3'd2, 8'h00, 1, 0);
    chk8("lsr", 8'hDA, 0, 1, 0);

    step(3'd1, 8'h81, 0, 0);
    step(3'd2, 8'h00, 0, 1);
    chk8("asr", 8'hC0, 1, 1, 0);
    step(3'd3, 8'h00, 0, 1);
    chk8("shl", 8'h80, 1, 2, 0);

    step(3'd1, 8'h01, 0, 0);
    for (int k = 1; k <= 7; k++)
      step(3'd3, 8'h00, 0, 0);
    chk8("shl7", 8'h80, 0, 7, 0);
    step(3'd3, 8'h00, 0, 0);
    chk8("shl8", 8'h00, 1, 8, 1);
    step(3'd3, 8'h00, 0, 0);
    chk8("shl9_sat", 8'h00, 0, 8, 1);

    step(3'd1, 8'h5B, 0, 0);
    step(3'd2, 8'h00, 0, 0);
    chk8("pre_idle", 8'h2D, 1, 1, 0);
    step(3'd0, 8'hFF, 1, 1);
    chk8("hold", 8'h2D, 1, 1, 0);
    step(3'd5, 8'hFF, 1, 1);
    chk8("rsv5", 8'h2D, 1, 1, 0);
    step(3'd7, 8'hFF, 1, 1);
    chk8("rsv7", 8'h2D, 1, 1, 0);
    step(3'd6, 8'hFF, 1, 1);
    chk8("rsv6", 8'h2D, 1, 1, 0);
    step(3'd4, 8'hFF, 1, 1);
    chk8("clr", 8'h00, 0, 0, 0);

    @(negedge clk);
    mode = 3'd0;
    m16 = 3'd1; d16 = 16'h8001;
    @(posedge clk); #1;
    chk("w16.load", 32'(out16), 32'h8001);
    @(negedge clk);
    m16 = 3'd3; s16 = 1'b1;
    @(posedge clk); #1;
    chk("w16.out",   32'(out16),  32'h0003);
    chk("w16.sout",  32'(sout16), 32'h1);
    chk("w16.count", 32'(cnt16),  32'(ec(1)));
    chk("w16.done",  32'(done16), 32'h0);
    chk("w8.idle",   32'(out8),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
